// File: rtl/cikis_toplayici.sv
// cikis_toplayici: packs the task unit's pixel stream into words,
// queues them in a small FIFO and tracks frame position/completion.
module cikis_toplayici #(
  parameter int GENISLIK      = 320,
  parameter int YUKSEKLIK     = 240,
  parameter int PIXEL_BIT     = 8,
  parameter int KELIME_PIXEL  = 4,
  parameter int FIFO_DERINLIK = 16
) (
  input  logic                              clk_i,
  input  logic                              rstn_i,
  input  logic                              basla_i,
  input  logic                              etkin_i,
  input  logic [PIXEL_BIT-1:0]              pixel_i,
  input  logic                              kelime_hazir_i,
  output logic                              kelime_gecerli_o,
  output logic [PIXEL_BIT*KELIME_PIXEL-1:0] kelime_o,
  output logic [16:0]                       adres_o,
  output logic [8:0]                        satir_o,
  output logic [8:0]                        sutun_o,
  output logic                              cerceve_bitti_o,
  output logic                              tasma_o,
  output logic                              mesgul_o
);

  localparam int W  = PIXEL_BIT * KELIME_PIXEL;
  localparam int AW = $clog2(FIFO_DERINLIK);
  localparam int PW = (KELIME_PIXEL > 1) ? $clog2(KELIME_PIXEL) : 1;

  localparam logic [AW:0]   TAM       = (AW+1)'(FIFO_DERINLIK);
  localparam logic [PW-1:0] SON_SLOT  = PW'(KELIME_PIXEL - 1);
  localparam logic [8:0]    SON_SUTUN = 9'(GENISLIK - 1);
  localparam logic [8:0]    SON_SATIR = 9'(YUKSEKLIK - 1);

  typedef enum logic [1:0] {
    BOSTA,
    TOPLA,
    BOSALT,
    BITTI
  } durum_t;

  durum_t durum;

  logic [PW-1:0] paket_sayac;
  logic [W-1:0]  paket;
  logic [16:0]   kelime_sayac;

  logic [W+16:0] mem [FIFO_DERINLIK];
  logic [AW-1:0] yaz_ptr;
  logic [AW-1:0] oku_ptr;
  logic [AW:0]   doluluk;

  logic          piksel_al;
  logic          son_piksel;
  logic          kelime_dolu;
  logic          dolu;
  logic          cek;
  logic          yaz;
  logic [W-1:0]  yeni_kelime;

  assign kelime_gecerli_o = (doluluk != '0);
  assign kelime_o = kelime_gecerli_o ? mem[oku_ptr][W-1:0] : '0;
  assign adres_o  = kelime_gecerli_o ? mem[oku_ptr][W +: 17] : '0;

  always_comb begin
    piksel_al   = (durum == TOPLA) && etkin_i && !basla_i;
    son_piksel  = piksel_al
                && (sutun_o == SON_SUTUN)
                && (satir_o == SON_SATIR);
    // the final pixel closes a partial word too; unused slots stay zero
    kelime_dolu = piksel_al
                && ((paket_sayac == SON_SLOT) || son_piksel);
    dolu        = (doluluk == TAM);
    cek         = kelime_gecerli_o && kelime_hazir_i;
    yaz         = kelime_dolu && (!dolu || cek);
    yeni_kelime = paket;
    for (int i = 0; i < KELIME_PIXEL; i++) begin
      if (paket_sayac == PW'(i)) begin
        yeni_kelime[i*PIXEL_BIT +: PIXEL_BIT] = pixel_i;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (yaz) begin
      mem[yaz_ptr] <= {kelime_sayac, yeni_kelime};
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      durum           <= BOSTA;
      paket_sayac     <= '0;
      paket           <= '0;
      kelime_sayac    <= '0;
      yaz_ptr         <= '0;
      oku_ptr         <= '0;
      doluluk         <= '0;
      satir_o         <= '0;
      sutun_o         <= '0;
      cerceve_bitti_o <= 1'b0;
      tasma_o         <= 1'b0;
      mesgul_o        <= 1'b0;
    end else if (basla_i) begin
      durum           <= TOPLA;
      paket_sayac     <= '0;
      paket           <= '0;
      kelime_sayac    <= '0;
      yaz_ptr         <= '0;
      oku_ptr         <= '0;
      doluluk         <= '0;
      satir_o         <= '0;
      sutun_o         <= '0;
      cerceve_bitti_o <= 1'b0;
      tasma_o         <= 1'b0;
      mesgul_o        <= 1'b1;
    end else begin
      cerceve_bitti_o <= 1'b0;

      unique case (durum)
        BOSTA: begin
          mesgul_o <= 1'b0;
        end
        TOPLA: begin
          if (son_piksel) begin
            durum <= BOSALT;
          end
        end
        BOSALT: begin
          if (doluluk == '0) begin
            durum           <= BITTI;
            cerceve_bitti_o <= 1'b1;
            mesgul_o        <= 1'b0;
          end
        end
        BITTI: begin
          durum <= BOSTA;
        end
        default: begin
          durum <= BOSTA;
        end
      endcase

      if (piksel_al) begin
        if (sutun_o == SON_SUTUN) begin
          sutun_o <= '0;
          satir_o <= (satir_o == SON_SATIR) ? '0 : satir_o + 9'd1;
        end else begin
          sutun_o <= sutun_o + 9'd1;
        end
        if (kelime_dolu) begin
          paket        <= '0;
          paket_sayac  <= '0;
          kelime_sayac <= kelime_sayac + 17'd1;
        end else begin
          paket        <= yeni_kelime;
          paket_sayac  <= paket_sayac + PW'(1);
        end
      end

      // a dropped word still consumes its address
      if (kelime_dolu && !yaz) begin
        tasma_o <= 1'b1;
      end

      if (yaz) begin
        yaz_ptr <= yaz_ptr + AW'(1);
      end
      if (cek) begin
        oku_ptr <= oku_ptr + AW'(1);
      end
      doluluk <= doluluk
               + {{AW{1'b0}}, yaz}
               - {{AW{1'b0}}, cek};
    end
  end

endmodule

// File: tb/tb_cikis_toplayici.sv
// tb_cikis_toplayici: vector table, directed corner sequences and a
// random run against a queue-based reference of the collector.
module tb_cikis_toplayici;

  localparam int G   = 10;
  localparam int H   = 11;
  localparam int TOT = G * H;
  localparam int DEP = 16;

  logic        clk_i = 1'b0;
  logic        rstn_i;
  logic        basla_i;
  logic        etkin_i;
  logic [7:0]  pixel_i;
  logic        kelime_hazir_i;
  logic        kelime_gecerli_o;
  logic [31:0] kelime_o;
  logic [16:0] adres_o;
  logic [8:0]  satir_o;
  logic [8:0]  sutun_o;
  logic        cerceve_bitti_o;
  logic        tasma_o;
  logic        mesgul_o;

  cikis_toplayici #(
    .GENISLIK(G),
    .YUKSEKLIK(H),
    .PIXEL_BIT(8),
    .KELIME_PIXEL(4),
    .FIFO_DERINLIK(DEP)
  ) dut (
    .clk_i(clk_i),
    .rstn_i(rstn_i),
    .basla_i(basla_i),
    .etkin_i(etkin_i),
    .pixel_i(pixel_i),
    .kelime_hazir_i(kelime_hazir_i),
    .kelime_gecerli_o(kelime_gecerli_o),
    .kelime_o(kelime_o),
    .adres_o(adres_o),
    .satir_o(satir_o),
    .sutun_o(sutun_o),
    .cerceve_bitti_o(cerceve_bitti_o),
    .tasma_o(tasma_o),
    .mesgul_o(mesgul_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [16:0] a;
    logic [31:0] d;
  } wrd_t;

  typedef struct {
    logic        b;
    logic        e;
    logic [7:0]  p;
    logic        h;
    logic        ev;
    logic [31:0] ew;
    logic [16:0] ea;
  } vec_t;

  int checks = 0;
  int errors = 0;

  // reference: pixel count, pending pixels, queued words, phase flags
  wrd_t       mq[$];
  logic [7:0] pend[$];
  int         npix;
  int         nwords;
  bit         m_col;
  bit         m_drn;
  bit         m_done;
  bit         m_tasma;

  int          xfers;
  int          pulses;
  logic [16:0] last_adr;

  task automatic chk(input string n, input logic [31:0] a,
                     input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    end
  endtask

  task automatic reset_model();
    mq.delete();
    pend.delete();
    npix    = 0;
    nwords  = 0;
    m_col   = 0;
    m_drn   = 0;
    m_done  = 0;
    m_tasma = 0;
  endtask

  task automatic model_edge(input bit b, input bit e,
                            input logic [7:0] p, input bit h);
    bit          fin;
    logic [31:0] w;
    wrd_t        x;
    if (b) begin
      reset_model();
      m_col = 1;
      return;
    end
    fin    = m_drn && (mq.size() == 0);
    m_done = 0;
    if (mq.size() != 0 && h) void'(mq.pop_front());
    if (m_col && e) begin
      pend.push_back(p);
      npix++;
      if (pend.size() == 4 || npix == TOT) begin
        w = '0;
        for (int i = 0; i < pend.size(); i++) w[8*i +: 8] = pend[i];
        x.a = 17'(nwords);
        x.d = w;
        if (mq.size() < DEP) mq.push_back(x);
        else m_tasma = 1;
        nwords++;
        pend.delete();
      end
      if (npix == TOT) begin
        m_col = 0;
        m_drn = 1;
      end
    end
    if (fin) begin
      m_drn  = 0;
      m_done = 1;
    end
  endtask

  task automatic compare();
    bit v;
    v = (mq.size() != 0);
    chk("valid", 32'(kelime_gecerli_o), 32'(v));
    if (v) begin
      chk("word", kelime_o, mq[0].d);
      chk("adr", 32'(adres_o), 32'(mq[0].a));
    end
    chk("satir", 32'(satir_o), 32'((npix / G) % H));
    chk("sutun", 32'(sutun_o), 32'(npix % G));
    chk("bitti", 32'(cerceve_bitti_o), 32'(m_done));
    chk("tasma", 32'(tasma_o), 32'(m_tasma));
    chk("mesgul", 32'(mesgul_o), 32'(m_col || m_drn));
  endtask

  task automatic step(input logic b, input logic e,
                      input logic [7:0] p, input logic h);
    if (kelime_gecerli_o && h) begin
      xfers++;
      last_adr = adres_o;
    end
    basla_i        = b;
    etkin_i        = e;
    pixel_i        = p;
    kelime_hazir_i = h;
    model_edge(b, e, p, h);
    @(posedge clk_i);
    @(negedge clk_i);
    compare();
    if (cerceve_bitti_o) pulses++;
  endtask

  vec_t tv[10];
  bit   rnd_end;

  initial begin
    rstn_i         = 1'b0;
    basla_i        = 1'b0;
    etkin_i        = 1'b0;
    pixel_i        = '0;
    kelime_hazir_i = 1'b0;
    xfers          = 0;
    pulses         = 0;
    last_adr       = '0;
    reset_model();
    repeat (2) @(negedge clk_i);
    compare();
    chk("rst_word", kelime_o, 32'h0);
    chk("rst_adr", 32'(adres_o), 32'h0);
    rstn_i = 1'b1;

    // two words back to back, each valid one cycle after its 4th pixel
    tv[0] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 32'h0, 17'd0};
    tv[1] = '{1'b0, 1'b1, 8'h01, 1'b1, 1'b0, 32'h0, 17'd0};
    tv[2] = '{1'b0, 1'b1, 8'h02, 1'b1, 1'b0, 32'h0, 17'd0};
    tv[3] = '{1'b0, 1'b1, 8'h03, 1'b1, 1'b0, 32'h0, 17'd0};
    tv[4] = '{1'b0, 1'b1, 8'h04, 1'b1, 1'b1, 32'h04030201, 17'd0};
    tv[5] = '{1'b0, 1'b1, 8'h05, 1'b1, 1'b0, 32'h0, 17'd0};
    tv[6] = '{1'b0, 1'b1, 8'h06, 1'b1, 1'b0, 32'h0, 17'd0};
    tv[7] = '{1'b0, 1'b1, 8'h07, 1'b1, 1'b0, 32'h0, 17'd0};
    tv[8] = '{1'b0, 1'b1, 8'h08, 1'b1, 1'b1, 32'h08070605, 17'd1};
    tv[9] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 32'h0, 17'd0};
    for (int i = 0; i < 10; i++) begin
      step(tv[i].b, tv[i].e, tv[i].p, tv[i].h);
      chk($sformatf("t1_valid%0d", i),
          32'(kelime_gecerli_o), 32'(tv[i].ev));
      if (tv[i].ev) begin
        chk($sformatf("t1_word%0d", i), kelime_o, tv[i].ew);
        chk($sformatf("t1_adr%0d", i), 32'(adres_o), 32'(tv[i].ea));
      end
    end

    // restart after 3 pixels drops the partial word
    step(1, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 8'hEE, 0);
    step(1, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 1, 8'(8'hA1 + i), 0);
    chk("t5_valid", 32'(kelime_gecerli_o), 32'd1);
    chk("t5_word", kelime_o, 32'hA4A3A2A1);
    chk("t5_adr", 32'(adres_o), 32'd0);

    // overflow: 20 words into 16 slots
    step(1, 0, 0, 0);
    for (int i = 0; i < 80; i++) step(0, 1, 8'(i), 0);
    chk("t3_tasma", 32'(tasma_o), 32'd1);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("t3_adr%0d", i), 32'(adres_o), 32'(i));
      step(0, 0, 0, 1);
    end
    chk("t3_empty", 32'(kelime_gecerli_o), 32'd0);
    for (int i = 0; i < 4; i++) step(0, 1, 8'(i), 0);
    chk("t3_adr20", 32'(adres_o), 32'd20);

    // full FIFO, pop and push on the same edge
    step(1, 0, 0, 0);
    for (int i = 0; i < 67; i++) step(0, 1, 8'(i), 0);
    step(0, 1, 8'h55, 1);
    chk("t4_tasma", 32'(tasma_o), 32'd0);
    chk("t4_head", 32'(adres_o), 32'd1);
    xfers = 0;
    for (int i = 0; i < 40; i++) step(0, 0, 0, 1);
    chk("t4_count", 32'(xfers), 32'd16);
    chk("t4_last", 32'(last_adr), 32'd16);

    // full frame, last word zero-padded
    step(1, 0, 0, 0);
    xfers  = 0;
    pulses = 0;
    for (int r = 0; r < H; r++)
      for (int c = 0; c < G; c++) step(0, 1, 8'(r + c), 1);
    for (int i = 0; i < 40; i++) step(0, 1, 8'hFF, 1);
    chk("t2_words", 32'(xfers), 32'((TOT + 3) / 4));
    chk("t2_last", 32'(last_adr), 32'((TOT + 3) / 4 - 1));
    chk("t2_pulses", 32'(pulses), 32'd1);

    // random traffic against the reference
    for (int f = 0; f < 3; f++) begin
      step(1, 0, 0, 0);
      rnd_end = 0;
      for (int k = 0; k < 2000 && !rnd_end; k++) begin
        step(f == 2 && $urandom_range(0, 149) == 0,
             $urandom_range(0, 3) != 0,
             8'($urandom),
             $urandom_range(0, 1) == 1);
        rnd_end = !m_col && !m_drn;
      end
      chk($sformatf("rnd_end%0d", f), 32'(rnd_end), 32'd1);
      for (int k = 0; k < 3; k++) step(0, 1, 8'($urandom), 1);
    end

    // asynchronous reset with five words queued
    step(1, 0, 0, 0);
    for (int i = 0; i < 20; i++) step(0, 1, 8'(i), 0);
    chk("t6_pre", 32'(kelime_gecerli_o), 32'd1);
    #2 rstn_i = 1'b0;
    #1;
    reset_model();
    compare();
    chk("t6_word", kelime_o, 32'h0);
    chk("t6_adr", 32'(adres_o), 32'h0);
    @(negedge clk_i);
    rstn_i = 1'b1;
    pulses = 0;
    for (int i = 0; i < 6; i++) step(0, 1, 8'(i), 1);
    chk("t6_pulse", 32'(pulses), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
